// File: rtl/ccff_bitstream_loader.sv
// Serialises a word-wide bitstream MSB-first into a configuration chain and
// captures the old chain contents emerging on ccff_tail as readback words.
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 20,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN+1)
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic [DATA_W-1:0] tail_data,
  output logic              tail_valid,
  output logic              busy,
  output logic              done,
  output logic              err_underrun
);
  localparam int BW = $clog2(DATA_W+1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  bit_cnt;   // bits consumed by the chain
  logic [CNT_W-1:0]  acc_cnt;   // bits accepted from the source
  logic [DATA_W-1:0] buf_q;
  logic [BW-1:0]     buf_cnt;   // bits still queued behind ccff_head
  logic [DATA_W-1:0] rb_acc;
  logic [BW-1:0]     rb_cnt;
  logic              head_q, shift_q, err_q, tvalid_q;
  logic [DATA_W-1:0] tdata_q;

  logic              more_words, hs, chain_end, rb_full;
  logic [31:0]       rem32;
  logic [BW-1:0]     nb, shamt;
  logic [DATA_W-1:0] rb_word;

  assign more_words = acc_cnt < CNT_W'(CHAIN_LEN);
  assign cfg_ready  = (state == ST_LOAD) && more_words && (!shift_q || buf_cnt == '0);
  assign hs         = cfg_valid && cfg_ready;
  assign chain_end  = shift_q && (bit_cnt == CNT_W'(CHAIN_LEN-1));

  // the final word may only contribute its upper bits
  assign rem32 = 32'(CHAIN_LEN) - 32'(acc_cnt);
  assign nb    = (rem32 >= 32'(DATA_W)) ? BW'(DATA_W) : BW'(rem32);

  assign rb_word = {rb_acc[DATA_W-2:0], ccff_tail};
  assign rb_full = (rb_cnt == BW'(DATA_W-1));
  assign shamt   = BW'(DATA_W-1) - rb_cnt;

  assign ccff_head     = head_q;
  assign ccff_shift_en = shift_q;
  assign tail_data     = tdata_q;
  assign tail_valid    = tvalid_q;
  assign busy          = (state == ST_LOAD);
  assign done          = (state == ST_DONE);
  assign err_underrun  = err_q;

  always_ff @(posedge prog_clk) begin
    if (!pReset_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      acc_cnt  <= '0;
      buf_q    <= '0;
      buf_cnt  <= '0;
      rb_acc   <= '0;
      rb_cnt   <= '0;
      head_q   <= 1'b0;
      shift_q  <= 1'b0;
      err_q    <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
    end else begin
      tvalid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_LOAD;
            bit_cnt <= '0;
            acc_cnt <= '0;
            buf_cnt <= '0;
            rb_acc  <= '0;
            rb_cnt  <= '0;
            shift_q <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (shift_q) begin
            bit_cnt <= bit_cnt + 1'b1;
            rb_acc  <= rb_word;
            if (rb_full || chain_end) begin
              tdata_q  <= rb_word << shamt;
              tvalid_q <= 1'b1;
              rb_cnt   <= '0;
            end else begin
              rb_cnt <= rb_cnt + 1'b1;
            end
          end
          if (hs) begin
            head_q  <= cfg_data[DATA_W-1];
            buf_q   <= cfg_data << 1;
            buf_cnt <= nb - 1'b1;
            acc_cnt <= acc_cnt + CNT_W'(nb);
            shift_q <= 1'b1;
          end else if (shift_q && buf_cnt != '0) begin
            head_q  <= buf_q[DATA_W-1];
            buf_q   <= buf_q << 1;
            buf_cnt <= buf_cnt - 1'b1;
          end else if (shift_q) begin
            // buffer ran dry: a stall unless the whole chain has been issued
            shift_q <= 1'b0;
            if (more_words) err_q <= 1'b1;
          end
          if (chain_end) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: directed table vectors, corner sequences and
// randomized loads checked against a bit-list model of stream and readback.
module tb_ccff_bitstream_loader;
  localparam int CL = 20;
  localparam int DW = 8;
  localparam int NW = (CL + DW - 1) / DW;

  logic          prog_clk = 1'b0;
  logic          pReset_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] cfg_data = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready, ccff_head, ccff_shift_en, ccff_tail;
  logic [DW-1:0] tail_data;
  logic          tail_valid, busy, done, err_underrun;

  always #5 prog_clk = ~prog_clk;

  ccff_bitstream_loader #(.CHAIN_LEN(CL), .DATA_W(DW)) dut (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
    .tail_data(tail_data), .tail_valid(tail_valid), .busy(busy), .done(done),
    .err_underrun(err_underrun)
  );

  // configuration chain model: first bit shifted in ends up at the tail end
  logic [CL-1:0] chain = '0;
  logic [CL-1:0] chain_init = '0;
  logic          chain_ld = 1'b0;
  always @(posedge prog_clk) begin
    if (chain_ld) chain <= chain_init;
    else if (ccff_shift_en) chain <= {chain[CL-2:0], ccff_head};
  end
  assign ccff_tail = chain[CL-1];

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [CL-1:0] exp_stream(input logic [DW-1:0] w[$]);
    logic [CL-1:0] s = '0;
    int n = 0;
    foreach (w[i])
      for (int b = DW-1; b >= 0; b--)
        if (n < CL) begin
          s = {s[CL-2:0], w[i][b]};
          n++;
        end
    return s;
  endfunction

  function automatic logic [DW-1:0] exp_tail(input int k, input logic [CL-1:0] s);
    logic [DW-1:0] r = '0;
    for (int j = 0; j < DW; j++)
      if (k*DW + j < CL) r[DW-1-j] = s[CL-1-(k*DW+j)];
    return r;
  endfunction

  typedef struct {
    logic [DW-1:0] w0, w1, w2;
    logic [CL-1:0] init;
    int            gap_at, gap_len, restart_at;
    logic [CL-1:0] stream;
    logic [DW-1:0] t0, t1, t2;
    bit            err;
    int            stall;
  } vec_t;

  logic [CL-1:0] last_stream;
  logic [DW-1:0] last_tails[$];
  bit            last_err;

  task automatic preload(input logic [CL-1:0] v);
    chain_init = v;
    chain_ld   = 1'b1;
    @(posedge prog_clk); #1;
    chain_ld   = 1'b0;
  endtask

  task automatic run_load(input string tag, input logic [DW-1:0] w[$], input int gap_at,
                          input int gap_len, input bit rnd, input int restart_at,
                          input int abort_at, input int exp_stall);
    logic [CL-1:0] snap = chain;
    logic [CL-1:0] got = '0;
    int nbits = 0, widx = 0, hs_n = 0, done_n = 0, stall_cyc = 0, gap_left = 0;
    int first_shift = -1, last_shift = -1, first_hs = -1, done_cyc = -1;
    logic last_head = 1'b0;
    bit seen_shift = 0, head_ok = 1, busy_ok = 1, tv_done_ok = 1, err_at_done = 0;
    bit aborted = 0, quiet_ok = 1;
    last_tails.delete();
    @(posedge prog_clk); #1;
    start = 1'b1;
    cfg_valid = 1'b0;
    @(posedge prog_clk); #1;
    start = 1'b0;
    chk({tag, " err_clr"}, err_underrun, 1'b0);
    for (int cyc = 1; cyc < 400 && done_cyc < 0; cyc++) begin
      if (ccff_shift_en) begin
        got = {got[CL-2:0], ccff_head};
        nbits++;
        if (first_shift < 0) first_shift = cyc;
        last_shift = cyc;
        last_head  = ccff_head;
        seen_shift = 1;
      end else if (seen_shift && busy) begin
        stall_cyc++;
        if (ccff_head !== last_head) head_ok = 0;
      end
      if (tail_valid) last_tails.push_back(tail_data);
      if (done) begin
        done_cyc = cyc;
        done_n++;
        err_at_done = err_underrun;
        if (!tail_valid) tv_done_ok = 0;
        if (busy) busy_ok = 0;
      end else if (!busy) busy_ok = 0;
      if (abort_at > 0 && nbits == abort_at && ccff_shift_en) begin
        aborted = 1;
        break;
      end
      start = (restart_at > 0 && nbits == restart_at && ccff_shift_en);
      if (gap_at > 0 && nbits == gap_at && ccff_shift_en) gap_left = gap_len;
      cfg_valid = (done_cyc < 0) && widx < w.size() && gap_left == 0 &&
                  (!rnd || $urandom_range(0, 3) != 0);
      if (gap_left > 0) gap_left--;
      cfg_data = cfg_valid ? w[widx] : DW'($urandom);
      if (cfg_valid && cfg_ready) begin
        hs_n++;
        if (first_hs < 0) first_hs = cyc;
        widx++;
      end
      @(posedge prog_clk); #1;
    end
    start = 1'b0;
    cfg_valid = 1'b0;
    if (aborted) begin
      pReset_n = 1'b0;
      @(posedge prog_clk); #1;
      pReset_n = 1'b1;
      chk({tag, " abort_outs"}, {cfg_ready, ccff_head, ccff_shift_en, tail_data, tail_valid,
                                 busy, done, err_underrun}, '0);
      repeat (4) begin
        @(posedge prog_clk); #1;
        if (done || busy || ccff_shift_en) quiet_ok = 0;
      end
      chk({tag, " abort_quiet"}, quiet_ok, 1'b1);
    end else begin
      repeat (3) begin
        @(posedge prog_clk); #1;
        if (done) done_n++;
        if (tail_valid) last_tails.push_back(tail_data);
      end
      last_stream = got;
      last_err    = err_at_done;
      chk({tag, " stream"}, got, exp_stream(w));
      chk({tag, " nbits"}, nbits, CL);
      chk({tag, " handshakes"}, hs_n, NW);
      chk({tag, " done_count"}, done_n, 1);
      chk({tag, " done_lat"}, done_cyc, last_shift + 1);
      chk({tag, " first_lat"}, first_shift, first_hs + 1);
      chk({tag, " tv_count"}, last_tails.size(), NW);
      for (int k = 0; k < NW && k < last_tails.size(); k++)
        chk({tag, " tail"}, last_tails[k], exp_tail(k, snap));
      chk({tag, " err"}, err_at_done, stall_cyc != 0);
      chk({tag, " head_hold"}, head_ok, 1'b1);
      chk({tag, " busy"}, busy_ok, 1'b1);
      chk({tag, " tv_at_done"}, tv_done_ok, 1'b1);
      if (exp_stall >= 0) chk({tag, " stall_cycles"}, stall_cyc, exp_stall);
    end
  endtask

  vec_t vecs[4];
  logic [DW-1:0] q[$];

  initial begin
    vecs[0] = '{8'hA5, 8'h3C, 8'hF0, 20'hFFFFF, 0, 0, 0, 20'hA53CF, 8'hFF, 8'hFF, 8'hF0, 1'b0, 0};
    vecs[1] = '{8'hA5, 8'h3C, 8'hF0, 20'hA53CF, 16, 4, 0, 20'hA53CF, 8'hA5, 8'h3C, 8'hF0, 1'b1, 4};
    vecs[2] = '{8'h12, 8'h34, 8'h56, 20'h00000, 0, 0, 5, 20'h12345, 8'h00, 8'h00, 8'h00, 1'b0, 0};
    vecs[3] = '{8'hFF, 8'h00, 8'hAB, 20'h0F0F0, 0, 0, 0, 20'hFF00A, 8'h0F, 8'h0F, 8'h00, 1'b0, 0};

    // reset held with start asserted
    pReset_n = 1'b0;
    start = 1'b1;
    repeat (3) begin
      @(posedge prog_clk); #1;
      chk("reset_outs", {cfg_ready, ccff_head, ccff_shift_en, tail_data, tail_valid,
                         busy, done, err_underrun}, '0);
    end
    start = 1'b0;
    pReset_n = 1'b1;
    @(posedge prog_clk); #1;
    chk("reset_idle", {busy, done, cfg_ready}, 3'b000);

    foreach (vecs[i]) begin
      preload(vecs[i].init);
      q = {vecs[i].w0, vecs[i].w1, vecs[i].w2};
      run_load($sformatf("vec%0d", i), q, vecs[i].gap_at, vecs[i].gap_len, 1'b0,
               vecs[i].restart_at, 0, vecs[i].stall);
      chk($sformatf("vec%0d tbl_stream", i), last_stream, vecs[i].stream);
      chk($sformatf("vec%0d tbl_tails", i),
          last_tails.size() == NW ? {last_tails[0], last_tails[1], last_tails[2]} : 24'hx,
          {vecs[i].t0, vecs[i].t1, vecs[i].t2});
      chk($sformatf("vec%0d tbl_err", i), last_err, vecs[i].err);
    end

    // reset after 9 bits, then a normal load must still complete
    preload(20'h5A5A5);
    q = {8'hA5, 8'h3C, 8'hF0};
    run_load("abort", q, 0, 0, 1'b0, 0, 9, -1);
    preload(20'hFFFFF);
    run_load("post_abort", q, 0, 0, 1'b0, 0, 0, 0);
    chk("post_abort tbl_stream", last_stream, 20'hA53CF);

    for (int r = 0; r < 6; r++) begin
      preload(CL'($urandom));
      q.delete();
      for (int k = 0; k < NW; k++) q.push_back(DW'($urandom));
      run_load($sformatf("rnd%0d", r), q, 0, 0, 1'b1, 0, 0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
